uc_sequencer: RTL
=================

Name: uc_sequencer

Overview:
- Multi-cycle control unit for the 4-bit X/Y/Z + ULA datapath; replaces the purely combinational opcode decode.
- Latches the memory word addressed by the PC and drives the register transfer codes (tX, tY, tZ) and the ULA function select (tULA) for exactly one execute cycle.
- Gates PC advance through pcEnable and supports run/stall, timed wait and halt.

Parameters:
- OPW, 4, opcode width (memoryFunction).
- VALW, 4, operand width (memoryValue); also the WAIT count width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = sequencer may fetch; 0 = park in FETCH.
- memoryFunction  in  OPW  opcode at the current PC.
- memoryValue  in  VALW  operand at the current PC.
- tX  out  2  regX transfer code.
- tY  out  2  regY transfer code.
- tZ  out  2  regZ transfer code.
- tULA  out  1  ULA select: 0 = add, 1 = subtract.
- pcEnable  out  1  one-cycle pulse that advances the PC.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse when an unknown opcode executes.
- state  out  3  current FSM state, for debug.

Behaviour:
- Transfer codes: 00 hold, 01 load, 10 clear to 0. The block never drives 11.
- Reset (asynchronous, high) takes effect immediately, including mid-instruction or mid-WAIT:
  - state = FETCH; IR = 0; waitCnt = 0.
  - All t codes = 00; tULA = 0; pcEnable = 0; halted = 0; illegal = 0.
- States and encoding: FETCH = 0, EXEC = 1, NEXT = 2, WAIT = 3, HALT = 4.
- FETCH:
  - If run = 1, latch IR <= memoryFunction and OPR <= memoryValue, then go to EXEC.
  - If run = 0, stay in FETCH; no latch.
- EXEC: lasts one cycle. Controls decode from IR only (Moore); the memory inputs are ignored.
  - 0 NOP: nothing.
  - 1 LDX: tX = 01.
  - 2 ADD: tULA = 0, tY = 01.
  - 3 SUB: tULA = 1, tY = 01.
  - 4 MOVZ: tZ = 01.
  - 5 CLRX: tX = 10.
  - 6 CLRY: tY = 10.
  - 7 CLRZ: tZ = 10.
  - 8 CLRALL: tX = tY = tZ = 10.
  - 9 WAIT: waitCnt <= OPR.
  - F HALT: no transfers.
  - A–E: treated as NOP; illegal = 1 for this cycle.
  - Next state: HALT if IR = F; WAIT if IR = 9 and OPR != 0; otherwise NEXT.
- WAIT:
  - All t codes = 00.
  - If waitCnt = 1, go to NEXT; else decrement waitCnt.
  - Exactly OPR cycles are spent in WAIT.
- NEXT: pcEnable = 1 for this cycle only, then go to FETCH.
- HALT:
  - halted = 1; pcEnable = 0; t codes = 00.
  - Exits only via reset; run is ignored.
- Outside EXEC, all t codes = 00 and tULA = 0, so registers hold.
- Instruction latency: 3 cycles (FETCH, EXEC, NEXT) plus OPR cycles for WAIT.
- run has no effect outside FETCH: an instruction that has been fetched always completes.
- An opcode change on memoryFunction during EXEC, WAIT or NEXT has no effect.
- pcEnable and illegal never assert in the same cycle.

Test Plan:
- Reset held during WAIT with waitCnt = 5 -> state = 0 immediately, before the next clk edge; all outputs 0; after release the next fetch occurs with run = 1.
- run = 1, program LDX 3; ADD; MOVZ -> EXEC cycles show tX = 01; then tULA = 0, tY = 01; then tZ = 01. pcEnable pulses on cycles 3, 6 and 9 after reset release, and never overlaps a t-code load.
- SUB with tULA check -> tULA = 1 only in the EXEC cycle; tULA = 0 in FETCH and NEXT.
- WAIT with memoryValue = 4 -> exactly 4 WAIT cycles, then one pcEnable. WAIT with 0 -> EXEC then NEXT directly, 3 cycles total.
- Opcode B -> illegal pulses for 1 cycle; no t code asserted; PC advances normally. CLRALL -> tX = tY = tZ = 10 in the same cycle.
- HALT -> halted = 1 from the cycle after EXEC; pcEnable stays 0 for 20+ cycles with run toggling; reset clears halted. run = 0 in FETCH for 10 cycles -> no latch, no pcEnable, state stays 0.

Source files
------------

// File: rtl/uc_sequencer.sv
// Multi-cycle control unit for the X/Y/Z + ULA datapath: fetches the word at the PC,
// drives one EXEC cycle of transfer/ULA controls, then pulses pcEnable; supports WAIT and HALT.
module uc_sequencer #(
   parameter int OPW  = 4,
   parameter int VALW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [OPW-1:0]  memoryFunction,
   input  logic [VALW-1:0] memoryValue,
   output logic [1:0]      tX,
   output logic [1:0]      tY,
   output logic [1:0]      tZ,
   output logic            tULA,
   output logic            pcEnable,
   output logic            halted,
   output logic            illegal,
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_NEXT  = 3'd2,
      S_WAIT  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [OPW-1:0] OP_NOP    = OPW'(0);
   localparam logic [OPW-1:0] OP_LDX    = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD    = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB    = OPW'(3);
   localparam logic [OPW-1:0] OP_MOVZ   = OPW'(4);
   localparam logic [OPW-1:0] OP_CLRX   = OPW'(5);
   localparam logic [OPW-1:0] OP_CLRY   = OPW'(6);
   localparam logic [OPW-1:0] OP_CLRZ   = OPW'(7);
   localparam logic [OPW-1:0] OP_CLRALL = OPW'(8);
   localparam logic [OPW-1:0] OP_WAIT   = OPW'(9);
   localparam logic [OPW-1:0] OP_HALT   = OPW'(15);

   localparam logic [1:0] T_HOLD  = 2'b00;
   localparam logic [1:0] T_LOAD  = 2'b01;
   localparam logic [1:0] T_CLEAR = 2'b10;

   state_t          cur_state;
   logic [OPW-1:0]  ir;
   logic [VALW-1:0] opr;
   logic [VALW-1:0] wait_cnt;

   assign state = cur_state;

   // Outputs are registered: the EXEC-cycle controls are decoded from the word being
   // latched into ir, so they appear exactly in the cycle ir holds that opcode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= S_FETCH;
         ir        <= '0;
         opr       <= '0;
         wait_cnt  <= '0;
         tX        <= T_HOLD;
         tY        <= T_HOLD;
         tZ        <= T_HOLD;
         tULA      <= 1'b0;
         pcEnable  <= 1'b0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         tX       <= T_HOLD;
         tY       <= T_HOLD;
         tZ       <= T_HOLD;
         tULA     <= 1'b0;
         pcEnable <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
         case (cur_state)
            S_FETCH: begin
               if (run) begin
                  ir        <= memoryFunction;
                  opr       <= memoryValue;
                  cur_state <= S_EXEC;
                  case (memoryFunction)
                     OP_NOP, OP_WAIT, OP_HALT: ;
                     OP_LDX:  tX <= T_LOAD;
                     OP_ADD:  tY <= T_LOAD;
                     OP_SUB: begin
                        tULA <= 1'b1;
                        tY   <= T_LOAD;
                     end
                     OP_MOVZ: tZ <= T_LOAD;
                     OP_CLRX: tX <= T_CLEAR;
                     OP_CLRY: tY <= T_CLEAR;
                     OP_CLRZ: tZ <= T_CLEAR;
                     OP_CLRALL: begin
                        tX <= T_CLEAR;
                        tY <= T_CLEAR;
                        tZ <= T_CLEAR;
                     end
                     default: illegal <= 1'b1;
                  endcase
               end
            end
            S_EXEC: begin
               if (ir == OP_WAIT) begin
                  wait_cnt <= opr;
               end
               if (ir == OP_HALT) begin
                  cur_state <= S_HALT;
                  halted    <= 1'b1;
               end else if (ir == OP_WAIT && opr != '0) begin
                  cur_state <= S_WAIT;
               end else begin
                  cur_state <= S_NEXT;
                  pcEnable  <= 1'b1;
               end
            end
            // wait_cnt starts at OPR on WAIT entry, so OPR cycles pass before NEXT.
            S_WAIT: begin
               if (wait_cnt == VALW'(1)) begin
                  cur_state <= S_NEXT;
                  pcEnable  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - VALW'(1);
               end
            end
            S_NEXT: cur_state <= S_FETCH;
            S_HALT: halted <= 1'b1;
            default: cur_state <= S_FETCH;
         endcase
      end
   end

endmodule
